// File: rtl/subsystem_button_pkg.sv
// subsystem_button_pkg: shared FSM type and sizing helpers for the push-button conditioner.
// Build option: defining SUBSYSTEM_BUTTON_LONG_PRESS_EN compiles in the long-press hold logic.
package subsystem_button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_fsm_e;

`ifdef SUBSYSTEM_BUTTON_LONG_PRESS_EN
  localparam bit LONG_PRESS_EN = 1'b1;
`else
  localparam bit LONG_PRESS_EN = 1'b0;
`endif

  // The prescaler produces one tick per millisecond.
  localparam int TICKS_PER_SEC = 1000;

  // Clock cycles between successive 1 ms ticks.
  function automatic int tick_div(input int clk_freq);
    return clk_freq / TICKS_PER_SEC;
  endfunction

  // Prescaler counter width.
  function automatic int prescale_width(input int clk_freq);
    return $clog2(tick_div(clk_freq));
  endfunction

  // Per-channel counter width: must hold the hold time when long-press is built in,
  // otherwise only the debounce time.
  function automatic int cnt_width(input int debounce_ms, input int long_ms);
    return LONG_PRESS_EN ? $clog2(long_ms + 1) : $clog2(debounce_ms + 1);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: one button channel -- two-flop synchroniser, polarity fix-up,
// four-state debounce FSM and (with SUBSYSTEM_BUTTON_LONG_PRESS_EN) the hold counter.
module button_debounce_ch
  import subsystem_button_pkg::*;
#(
  parameter bit INVERTED    = 1'b0,
  parameter int DEBOUNCE_MS = 10,
`ifdef SUBSYSTEM_BUTTON_LONG_PRESS_EN
  parameter int LONG_MS     = 1000,
`endif
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic tick,
  input  logic ready,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [1:0]       sync_ff;
  logic             sync;
  btn_fsm_e         state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic             level_nxt, press_nxt, rel_nxt;

  // Bring the asynchronous pin into the clock domain before any decision is made on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= 2'b00;
    else        sync_ff <= {sync_ff[0], pin};
  end

  assign sync = sync_ff[1] ^ INVERTED;

  // Debounce FSM: a new level must persist for DEBOUNCE_MS ticks; strobes are muted until ready.
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    level_nxt = level;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      RELEASED: begin
        if (sync) begin
          state_nxt = PRESS_PEND;
          deb_nxt   = '0;
        end
      end
      PRESS_PEND: begin
        if (!sync) begin
          state_nxt = RELEASED;
        end else if (tick) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt = PRESSED;
            level_nxt = 1'b1;
            press_nxt = ready;
          end else begin
            deb_nxt = deb_cnt + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_nxt = RELEASE_PEND;
          deb_nxt   = '0;
        end
      end
      RELEASE_PEND: begin
        if (sync) begin
          state_nxt = PRESSED;
        end else if (tick) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt = RELEASED;
            level_nxt = 1'b0;
            rel_nxt   = ready;
          end else begin
            deb_nxt = deb_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = RELEASED;
        level_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, debounce counter and registered level/strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RELEASED;
      deb_cnt <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      state   <= state_nxt;
      deb_cnt <= deb_nxt;
      level   <= level_nxt;
      press   <= press_nxt;
      rel     <= rel_nxt;
    end
  end

`ifdef SUBSYSTEM_BUTTON_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_MS - 1);

  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             no_event, no_event_nxt;
  logic             long_q, long_nxt;

  // Hold counter restarts on each accepted press, saturates so the long strobe fires once,
  // and is frozen (not cleared) while a release is only pending. A press already in progress
  // before start-up settles is marked no-event so it never produces a long strobe.
  always_comb begin
    hold_nxt     = hold_cnt;
    long_nxt     = 1'b0;
    no_event_nxt = no_event;
    if (state == PRESS_PEND && state_nxt == PRESSED) begin
      hold_nxt = '0;
    end else if (state == PRESSED && tick && hold_cnt != HOLD_MAX) begin
      hold_nxt = hold_cnt + 1'b1;
      long_nxt = (hold_cnt == HOLD_LAST) && ready && !no_event;
    end
    if (state_nxt == RELEASED) begin
      no_event_nxt = 1'b0;
    end else if (!ready && (state_nxt == PRESSED || state_nxt == RELEASE_PEND)) begin
      no_event_nxt = 1'b1;
    end
  end

  // Hold counter, no-event flag and long-press strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      no_event <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      no_event <= no_event_nxt;
      long_q   <= long_nxt;
    end
  end

  assign hold = long_q;
`else
  assign hold = 1'b0;
`endif

endmodule

// File: rtl/subsystem_button.sv
// subsystem_button: front-panel button conditioner -- shared 1 ms prescaler, start-up
// settling counter driving ready, and one debounce channel per button.
// Build option: SUBSYSTEM_BUTTON_LONG_PRESS_EN enables the per-channel btn_long strobe.
module subsystem_button
  import subsystem_button_pkg::*;
#(
  parameter int CLK_FREQ    = 125000000,
  parameter int NUM_BTN     = 4,
  parameter bit INVERTED    = 1'b0,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic               ready
);

  localparam int TICK_DIV = tick_div(CLK_FREQ);
  localparam int PRE_W    = prescale_width(CLK_FREQ);
  localparam int CNT_W    = cnt_width(DEBOUNCE_MS, LONG_MS);
  localparam int SU_W     = $clog2(DEBOUNCE_MS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(DEBOUNCE_MS - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [SU_W-1:0]  su_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_LAST);

  // Free-running millisecond prescaler shared by all channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Start-up window: ready rises once DEBOUNCE_MS ticks have elapsed since reset, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      su_cnt <= '0;
      ready  <= 1'b0;
    end else if (!ready && tick) begin
      if (su_cnt == SU_LAST) ready  <= 1'b1;
      else                   su_cnt <= su_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .INVERTED    (INVERTED),
      .DEBOUNCE_MS (DEBOUNCE_MS),
`ifdef SUBSYSTEM_BUTTON_LONG_PRESS_EN
      .LONG_MS     (LONG_MS),
`endif
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (btn_in[i]),
      .tick  (tick),
      .ready (ready),
      .level (btn_state[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i]),
      .hold  (btn_long[i])
    );
  end

endmodule
